muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/cond_negate.sv | 12 +
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the step-counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;

  // Step counter width: clog2 of the operand width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement: y = neg ? -x : x.
module cond_negate #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);

  assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with MIPS-style HI/LO results and a
// start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prime_q, prime_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [1:0]       op_q;
  logic             sa_q, sb_q, bz_q;
  logic [WIDTH-1:0] a_raw_q, mag_a_q, mag_b_q;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             load_c;

  // Operand magnitudes for signed ops, taken at the accepting edge.
  logic             in_signed_c;
  logic [WIDTH-1:0] abs_a_c, abs_b_c;

  assign in_signed_c = (op == OP_MULT) || (op == OP_DIV);

  cond_negate #(.N(WIDTH)) u_abs_a (.x(a), .neg(in_signed_c & a[WIDTH-1]), .y(abs_a_c));
  cond_negate #(.N(WIDTH)) u_abs_b (.x(b), .neg(in_signed_c & b[WIDTH-1]), .y(abs_b_c));

  // One radix-2 step of shift-add multiply and restoring divide.
  logic             is_div_c;
  logic [WIDTH:0]   sum_c, shifted_c, diff_c;
  logic [W2-1:0]    mul_step_c, div_step_c;

  assign is_div_c   = (op_q == OP_DIVU) || (op_q == OP_DIV);
  assign sum_c      = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mag_b_q};
  assign mul_step_c = acc_q[0] ? {sum_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
  assign shifted_c  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign diff_c     = shifted_c - {1'b0, mag_b_q};
  assign div_step_c = diff_c[WIDTH]
                    ? {shifted_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {diff_c[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b1};

  // Sign fix-up; unsigned ops never set sa_q/sb_q so these pass through.
  logic [W2-1:0]    prod_c;
  logic [WIDTH-1:0] quo_c, rem_c;

  cond_negate #(.N(W2))    u_prod (.x(acc_q),              .neg(sa_q ^ sb_q), .y(prod_c));
  cond_negate #(.N(WIDTH)) u_quo  (.x(acc_q[WIDTH-1:0]),   .neg(sa_q ^ sb_q), .y(quo_c));
  cond_negate #(.N(WIDTH)) u_rem  (.x(acc_q[W2-1:WIDTH]),  .neg(sa_q),        .y(rem_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prime_q <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_MULTU;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_raw_q <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
    end else if (load_c) begin
      op_q    <= op;
      sa_q    <= in_signed_c & a[WIDTH-1];
      sb_q    <= in_signed_c & b[WIDTH-1];
      bz_q    <= (b == '0);
      a_raw_q <= a;
      mag_a_q <= abs_a_c;
      mag_b_q <= abs_b_c;
    end
  end

  // Next-state and datapath control; the first CALC cycle loads the accumulator.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prime_d = prime_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    load_c  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH - 1);
          prime_d = 1'b1;
          load_c  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (prime_q) begin
          prime_d = 1'b0;
          acc_d   = {{WIDTH{1'b0}}, mag_a_q};
        end else begin
          acc_d = is_div_c ? div_step_c : mul_step_c;
          if (cnt_q == '0) state_d = SIGN;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      SIGN: begin
        state_d = DONE;
        dbz_d   = is_div_c & bz_q;
        if (!is_div_c) begin
          hi_d = prod_c[W2-1:WIDTH];
          lo_d = prod_c[WIDTH-1:0];
        end else if (bz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_c;
          lo_d = quo_c;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           k;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact 64-bit arithmetic; SV division truncates toward zero.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t          r;
    longint        sx, sy;
    longint unsigned ux, uy;
    logic [63:0]   t, t2;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'b0, x};
    uy = {32'b0, y};
    r.dbz = 1'b0;
    r.k = 0;
    case (o)
      2'b00: begin t = ux * uy; r.hi = t[63:32]; r.lo = t[31:0]; end
      2'b01: begin t = sx * sy; r.hi = t[63:32]; r.lo = t[31:0]; end
      default: begin
        if (y == '0) begin
          r.dbz = 1'b1; r.hi = x; r.lo = '1;
        end else if (o == 2'b10) begin
          t = ux / uy; t2 = ux % uy; r.lo = t[31:0]; r.hi = t2[31:0];
        end else begin
          t = sx / sy; t2 = sx % sy; r.lo = t[31:0]; r.hi = t2[31:0];
        end
      end
    endcase
    return r;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done at cyc %0d: hi=%h lo=%h dbz=%b", cyc, hi, lo, div_by_zero);
      end else begin
        mon_e = sb.pop_front();
        if (hi !== mon_e.hi || lo !== mon_e.lo || div_by_zero !== mon_e.dbz || cyc != mon_e.k + W + 2) begin
          fails++;
          $display("FAIL result: got hi=%h lo=%h dbz=%b cyc=%0d, want hi=%h lo=%h dbz=%b cyc=%0d",
                   hi, lo, div_by_zero, cyc, mon_e.hi, mon_e.lo, mon_e.dbz, mon_e.k + W + 2);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; waits for busy=0, issues one op, then scrambles inputs.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL issue_timeout: busy=%b want 0", busy);
    end
    op = o; a = x; b = y; start = 1'b1;
    e = model(o, x, y);
    e.k = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin @(negedge clk); n++; end
    tests++;
    if (sb.size() != 0 || busy) begin
      fails++;
      $display("FAIL wait_idle_timeout: pending=%0d busy=%b want 0/0", sb.size(), busy);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();

    // MULT then DIV started in the DONE cycle
    issue(2'b01, 32'hFFFFFFFD, 32'd7);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("b2b_done_seen", {31'b0, done}, 32'd1);
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_idle();

    issue(2'b10, 32'd100, 32'd0);
    wait_idle();
    chk("dbz_hold_flag", {31'b0, div_by_zero}, 32'd1);
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF);
    issue(2'b10, 32'd7, 32'd9);
    issue(2'b11, 32'h80000000, 32'd0);
    wait_idle();
    chk("hold_hi", hi, 32'h80000000);
    chk("hold_lo", lo, 32'hFFFFFFFF);

    // start and operand changes while busy must be ignored
    issue(2'b10, 32'd50, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd123; b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h1;
    wait_idle();

    // asynchronous reset mid-operation
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_late_busy", {31'b0, busy}, 32'd0);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();

    // random back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      issue(2'($urandom_range(0, 3)), ra, rb);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
